imem_loader: RTL and testbench

Write-side companion to the instruction fetch stage. It accepts 32-bit instruction words over a valid/ready handshake and writes them into the byte-wide instruction memory as four big-endian bytes. Word N's most significant byte lands at address 4N, so a fetch at PC returns the word exactly as written. It asserts cpu_run once the program is resident; integration ANDs cpu_run with the hazard stall term to form the fetch stage's PC_write.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_byte_sel.sv | 21 ++
 rtl/imem_loader.sv | 87 ++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage:
// memory geometry defaults, FSM encoding and big-endian byte-lane order.
package imem_loader_pkg;

  localparam int DEF_MEM_BYTES = 20;
  localparam int DEF_ADDR_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BYTE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lane index = byte offset within the word; offset 0 carries the MSB.
  localparam logic [1:0] LANE_B3   = 2'd0;
  localparam logic [1:0] LANE_B2   = 2'd1;
  localparam logic [1:0] LANE_B1   = 2'd2;
  localparam logic [1:0] LANE_B0   = 2'd3;
  localparam logic [1:0] LAST_LANE = LANE_B0;

endpackage

// File: rtl/imem_byte_sel.sv
// Big-endian 32-to-8 lane mux: byte offset 0 selects bits 31:24.
module imem_byte_sel
  import imem_loader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_idx,
  output logic [7:0]  byte_out
);

  always_comb begin
    byte_out = 8'h00;
    case (byte_idx)
      LANE_B3: byte_out = word[31:24];
      LANE_B2: byte_out = word[23:16];
      LANE_B1: byte_out = word[15:8];
      LANE_B0: byte_out = word[7:0];
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Accepts 32-bit instruction words over valid/ready and writes them into the
// byte-wide instruction memory as four big-endian bytes; raises cpu_run when done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-3:0] words_loaded,
  output logic              load_done,
  output logic              cpu_run
);

  // Base address of the final word slot; writing it fills the memory.
  localparam logic [ADDR_W-1:0] BASE_MAX = ADDR_W'(MEM_BYTES - 4);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic              last;
  logic [7:0]        lane_byte;

  imem_byte_sel u_byte_sel (
    .word     (word),
    .byte_idx (byte_idx),
    .byte_out (lane_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      base         <= '0;
      byte_idx     <= '0;
      words_loaded <= '0;
      word         <= '0;
      last         <= 1'b0;
    end else if (restart) begin
      state        <= ST_IDLE;
      base         <= '0;
      byte_idx     <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_valid && wr_ready) begin
            word     <= wr_data;
            last     <= wr_last;
            byte_idx <= '0;
            state    <= ST_BYTE;
          end
        end
        ST_BYTE: begin
          if (byte_idx == LAST_LANE) begin
            byte_idx     <= '0;
            base         <= base + ADDR_W'(4);
            words_loaded <= words_loaded + (ADDR_W-2)'(1);
            state        <= (last || base == BASE_MAX) ? ST_DONE : ST_IDLE;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Restart blocks acceptance in its own cycle so a coincident word is not lost silently.
  assign wr_ready  = rst_n && (state == ST_IDLE) && !restart;
  assign mem_we    = (state == ST_BYTE);
  assign mem_addr  = mem_we ? (base + ADDR_W'(byte_idx)) : '0;
  assign mem_wdata = mem_we ? lane_byte : 8'h00;
  assign load_done = (state == ST_DONE);
  assign cpu_run   = load_done;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader against a queue-based write model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MEM_BYTES = 20;
  localparam int ADDR_W    = 5;
  localparam int NWORDS    = MEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              wr_last = 1'b0;
  logic              restart = 1'b0;
  logic              wr_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-3:0] words_loaded;
  logic              load_done;
  logic              cpu_run;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .restart      (restart),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .load_done    (load_done),
    .cpu_run      (cpu_run)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    bit                eow;
    bit                last;
  } wr_t;

  wr_t         q[$];
  int          m_words;
  int          m_base;
  bit          m_done;
  bit          accepted;
  logic [7:0]  tb_mem [0:31];
  int          oob;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_words = 0;
    m_base  = 0;
    m_done  = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) tb_mem[i] = 8'hxx;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_run"},   32'(cpu_run), 32'd0);
  endtask

  // One clock: compare outputs with the model mid-cycle, then advance the model.
  task automatic cycle();
    bit  exp_ready;
    wr_t w;
    @(negedge clk);
    exp_ready = (q.size() == 0) && !m_done && !restart;
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    check("mem_we", 32'(mem_we), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("mem_addr", 32'(mem_addr), 32'(q[0].addr));
      check("mem_wdata", 32'(mem_wdata), 32'(q[0].data));
    end
    check("load_done", 32'(load_done), 32'(m_done));
    check("cpu_run", 32'(cpu_run), 32'(m_done));
    check("words_loaded", 32'(words_loaded), 32'(m_words));
    if (mem_we) begin
      if (32'(mem_addr) >= MEM_BYTES) oob++;
      else tb_mem[mem_addr] = mem_wdata;
    end
    accepted = 1'b0;
    if (restart) begin
      model_reset();
    end else if (q.size() != 0) begin
      w = q.pop_front();
      if (w.eow) begin
        m_words++;
        m_base += 4;
        if (w.last || m_words == NWORDS) m_done = 1'b1;
      end
    end else if (exp_ready && wr_valid) begin
      for (int i = 0; i < 4; i++) begin
        w.addr = ADDR_W'(m_base + i);
        w.data = wr_data[31-8*i -: 8];
        w.eow  = (i == 3);
        w.last = wr_last;
        q.push_back(w);
      end
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_word(input logic [31:0] data, input logic last_in);
    bit got;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last_in;
    for (int c = 0; c < 20 && !got; c++) begin
      cycle();
      got = accepted;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  logic [31:0] words5 [0:4];
  logic [31:0] wa;
  logic [31:0] wb;
  int          widx;

  initial begin
    n_checks = 0;
    n_errors = 0;
    oob      = 0;
    model_reset();
    clear_mem();

    // Reset values while rst_n is held low.
    #2;
    check_reset_outputs("rst");
    check("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word with wr_last.
    send_word(32'h08410002, 1'b1);
    idle(6);
    check("t1_mem", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h08410002);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_words", 32'(words_loaded), 32'd1);

    // Five back-to-back words, full condition ends the load.
    pulse_restart();
    clear_mem();
    words5[0] = 32'h08410002;
    words5[1] = $urandom;
    words5[2] = $urandom;
    words5[3] = $urandom;
    words5[4] = 32'h05490016;
    widx = 0;
    wr_valid = 1'b1;
    wr_last  = 1'b0;
    for (int c = 0; c < 60 && !m_done; c++) begin
      wr_data = words5[widx < 5 ? widx : 4];
      cycle();
      if (accepted) widx++;
    end
    idle(4);
    wr_valid = 1'b0;
    check("t2_mem19", 32'(tb_mem[19]), 32'h16);
    check("t2_last_word", {tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]}, 32'h05490016);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_words", 32'(words_loaded), 32'(NWORDS));
    check("t2_oob", 32'(oob), 32'd0);

    // Two words with a valid gap between them.
    pulse_restart();
    clear_mem();
    wa = $urandom;
    wb = $urandom;
    send_word(wa, 1'b0);
    idle(7);
    send_word(wb, 1'b1);
    idle(6);
    check("t3_w0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, wa);
    check("t3_w1", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, wb);

    // Restart while byte 2 of word 1 is on the bus.
    pulse_restart();
    send_word($urandom, 1'b0);
    idle(4);
    send_word($urandom, 1'b0);
    idle(2);
    check("t4_byte2", 32'(mem_addr), 32'd6);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    clear_mem();
    check("t4_no_we", 32'(mem_we), 32'd0);
    send_word(32'h00E64000, 1'b1);
    idle(5);
    check("t4_mem", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h00E64000);

    // Restart from DONE, then a two-word program.
    pulse_restart();
    check("t5_run_drop", 32'(cpu_run), 32'd0);
    send_word($urandom, 1'b0);
    idle(4);
    send_word($urandom, 1'b1);
    idle(6);
    check("t5_words", 32'(words_loaded), 32'd2);
    check("t5_run", 32'(cpu_run), 32'd1);

    // Asynchronous reset in the middle of a byte sequence.
    pulse_restart();
    send_word($urandom, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Randomized traffic with occasional restarts.
    for (int c = 0; c < 1500; c++) begin
      wr_valid = ($urandom % 3) != 0;
      wr_data  = $urandom;
      wr_last  = ($urandom % 8) == 0;
      restart  = (($urandom % 50) == 0) || (m_done && ($urandom % 4) == 0);
      cycle();
    end
    restart  = 1'b0;
    wr_valid = 1'b0;
    check("final_oob", 32'(oob), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
